// File: rtl/core_fetch.sv
// core_fetch: in-order instruction fetch stage with an outstanding-fetch queue.
// Requests carry the current pc; responses fill queue entries in order and the
// head entry is presented to decode. A redirect restarts at a new pc and counts
// the still-in-flight responses so they can be discarded when they return.
// Optional: CORE_FETCH_BYPASS_EN lets a response reach decode in the same cycle
// when the head entry is waiting for it.
module core_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_ir,
  input  logic        d_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        filled;
  } entry_t;

  entry_t      q [FIFO_DEPTH];
  ptr_t        head, tail, fptr;   // fptr: oldest unfilled entry
  cnt_t        count;              // entries in the queue
  cnt_t        pend;               // entries still waiting for their response
  cnt_t        drop_cnt;           // stale responses still to be discarded
  logic [31:0] pc;

  logic        credit, issue, rsp_drop, rsp_take, head_filled, byp, pop;
  logic [CW:0] used;

  // Credit, handshakes and decode presentation.
  always_comb begin
    used           = {1'b0, count} + {1'b0, drop_cnt};
    credit         = used < (CW+1)'(FIFO_DEPTH);
    imem_req_valid = rst_n & ~redirect_valid & credit;
    imem_req_addr  = pc;
    issue          = imem_req_valid & imem_req_ready;
    rsp_drop       = imem_rsp_valid & (drop_cnt != '0);
    rsp_take       = imem_rsp_valid & (drop_cnt == '0) & (pend != '0);
    head_filled    = (count != '0) & q[head].filled;
`ifdef CORE_FETCH_BYPASS_EN
    // Responses are in order, so an unfilled head is exactly the entry this
    // response belongs to.
    byp            = rsp_take & ~q[head].filled;
    d_ir           = head_filled ? q[head].ir : imem_rsp_data;
`else
    byp            = 1'b0;
    d_ir           = q[head].ir;
`endif
    d_valid        = (head_filled | byp) & ~redirect_valid;
    d_pc           = q[head].pc;
    pop            = d_valid & d_ready;
  end

  // Queue, pointers, pc and drop bookkeeping; redirect overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      count    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) q[i] <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      count    <= '0;
      pend     <= '0;
      // Every unfilled entry still has a response coming; one may land now.
      drop_cnt <= drop_cnt + pend - cnt_t'(imem_rsp_valid);
    end else begin
      if (issue) begin
        q[tail] <= '{pc: pc, ir: 32'h0, filled: 1'b0};
        tail    <= tail + ptr_t'(1);
        pc      <= pc + 32'd4;
      end
      if (rsp_drop) drop_cnt <= drop_cnt - cnt_t'(1);
      if (rsp_take) begin
        // A bypassed-and-consumed response never needs to be stored.
        if (!(byp && pop)) begin
          q[fptr].ir     <= imem_rsp_data;
          q[fptr].filled <= 1'b1;
        end
        fptr <= fptr + ptr_t'(1);
      end
      if (pop) head <= head + ptr_t'(1);
      count <= count + cnt_t'(issue) - cnt_t'(pop);
      pend  <= pend + cnt_t'(issue) - cnt_t'(rsp_take);
    end
  end

endmodule
